adder: RTL and testbench

//   Registered unsigned adder used as the lab's synthesis/gate-sim vehicle.
//   - Adds two 7-bit unsigned operands into an 8-bit sum with the carry kept.
//   - The result passes through a clock-enabled register pipeline of

---
 rtl/adder.sv | 30 +++
 tb/tb_adder.sv | 116 +++++++++++
 2 files changed

// File: rtl/adder.sv
// adder: unsigned IN_W-bit adder whose carry-kept sum runs through a clock-enabled pipeline of LATENCY flops.
// rst_n is a synchronous active-high reset; out is driven directly by the last flop.
module adder #(
    parameter int IN_W    = 7,
    parameter int LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IN_W-1:0] in_a,
    input  logic [IN_W-1:0] in_b,
    input  logic            enable,
    output logic [IN_W:0]   out
);
    logic [IN_W:0] sum;
    logic [IN_W:0] stage [LATENCY];

    assign sum = {1'b0, in_a} + {1'b0, in_b};

    // Reset beats enable; enable=0 freezes every stage at once.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < LATENCY; k++) stage[k] <= '0;
        end else if (enable) begin
            stage[0] <= sum;
            for (int k = 1; k < LATENCY; k++) stage[k] <= stage[k-1];
        end
    end

    assign out = stage[LATENCY-1];
endmodule

// File: tb/tb_adder.sv
// tb_adder: drives a LATENCY=1 and a LATENCY=3 adder in parallel and checks both against a
// model that keeps the list of sums accepted since the last reset.
module tb_adder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [6:0] in_a, in_b;
    logic [7:0] o1, o3;

    int checks = 0;
    int failures = 0;

    logic [7:0] hist [$];
    logic [7:0] q1 [$];
    logic [7:0] q3 [$];
    string      qt [$];

    string      t;
    logic [7:0] e1, e3;

    adder #(.IN_W(7), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .enable(enable), .out(o1)
    );
    adder #(.IN_W(7), .LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .enable(enable), .out(o3)
    );

    always #5 clk = ~clk;

    // Result visible after an edge is the one accepted L accepts ago, or 0 if too few accepts.
    function automatic logic [7:0] expv(input int l);
        return (hist.size() >= l) ? hist[hist.size() - l] : 8'd0;
    endfunction

    task automatic step(input logic [6:0] x, input logic [6:0] y, input logic e, input logic r,
                        input string tag);
        in_a   = x;
        in_b   = y;
        enable = e;
        rst_n  = r;
        if (r) hist.delete();
        else if (e) begin
            hist.push_back(8'(x) + 8'(y));
            if (hist.size() > 4) void'(hist.pop_front());
        end
        q1.push_back(expv(1));
        q3.push_back(expv(3));
        qt.push_back(tag);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (qt.size() > 0) begin
            t  = qt.pop_front();
            e1 = q1.pop_front();
            e3 = q3.pop_front();
            checks += 2;
            if (o1 !== e1) begin
                failures++;
                $display("FAIL %s lat1: out=%0d expected=%0d", t, o1, e1);
            end
            if (o3 !== e3) begin
                failures++;
                $display("FAIL %s lat3: out=%0d expected=%0d", t, o3, e3);
            end
        end
    end

    initial begin
        rst_n  = 1'b1;
        enable = 1'b0;
        in_a   = '0;
        in_b   = '0;
        @(negedge clk);

        step(7'd55, 7'd66, 1'b1, 1'b1, "reset0");
        step(7'd55, 7'd66, 1'b1, 1'b1, "reset1");
        step(7'd55, 7'd66, 1'b1, 1'b0, "release");

        step(7'd0,   7'd0,   1'b1, 1'b0, "c_0_0");
        step(7'd127, 7'd0,   1'b1, 1'b0, "c_127_0");
        step(7'd127, 7'd1,   1'b1, 1'b0, "c_127_1");
        step(7'd127, 7'd127, 1'b1, 1'b0, "c_127_127");
        step(7'd0,   7'd0,   1'b1, 1'b0, "c_flush1");
        step(7'd0,   7'd0,   1'b1, 1'b0, "c_flush2");

        for (int i = 0; i < 1000; i++)
            step(7'($urandom), 7'($urandom), 1'b1, 1'b0, "rand_b2b");

        step(7'd10, 7'd20, 1'b1, 1'b0, "hold_load");
        for (int i = 0; i < 3; i++) step(7'd100, 7'd100, 1'b0, 1'b0, "hold");
        step(7'd100, 7'd100, 1'b1, 1'b0, "hold_resume");
        step(7'd100, 7'd100, 1'b1, 1'b0, "hold_resume2");

        step(7'd0, 7'd0, 1'b1, 1'b1, "mid_pre_rst");
        step(7'd1, 7'd1, 1'b1, 1'b0, "mid_feed1");
        step(7'd2, 7'd2, 1'b1, 1'b0, "mid_feed2");
        step(7'd3, 7'd3, 1'b1, 1'b0, "mid_feed3");
        step(7'd4, 7'd4, 1'b1, 1'b1, "mid_rst");
        for (int i = 0; i < 5; i++) step(7'(9 + i), 7'd9, 1'b1, 1'b0, "mid_after");

        for (int i = 0; i < 400; i++)
            step(7'($urandom), 7'($urandom), ($urandom % 4) != 0, ($urandom % 50) == 0, "rand_mix");

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (qt.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d expected=0", qt.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
